// File: rtl/lru_req_queue_if.sv
// Bundle of handshake signals between lru_req_queue and its neighbours:
// requester push ports, the arbiter request/grant pair and the downstream
// valid/ready output stage.
//   master : the environment side (requesters, arbiter, downstream consumer)
//   slave  : the lru_req_queue side
interface lru_req_queue_if #(
    parameter int unsigned NUM_REQ = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        gnt;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      gnt_err;

    modport master (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, req, out_valid, out_data, out_src, gnt_err
    );

    modport slave (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, req, out_valid, out_data, out_src, gnt_err
    );
endinterface

// File: rtl/lru_req_queue.sv
// Per-requester ingress FIFOs in front of an LRU matrix arbiter.
// Each requester pushes into its own DEPTH-entry FIFO; non-empty FIFOs raise
// req while the output stage can take a word; the arbiter's one-hot gnt pops
// the winning FIFO and the payload is registered into a valid/ready stage.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_b : asynchronous active-low reset
//   bus   : lru_req_queue_if.slave (push ports, req/gnt, output stage, gnt_err)
module lru_req_queue #(
    parameter int unsigned NUM_REQ = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input logic            clk,
    input logic            rst_b,
    lru_req_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q   [NUM_REQ][DEPTH];
    logic [CNT_W-1:0]  count_q [NUM_REQ];
    logic [PTR_W-1:0]  wptr_q  [NUM_REQ];
    logic [PTR_W-1:0]  rptr_q  [NUM_REQ];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;
    logic              gnt_err_q;

    logic               slot_free;
    logic [NUM_REQ-1:0] in_ready_w;
    logic [NUM_REQ-1:0] req_w;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               gnt_onehot;
    logic               gnt_legal;
    logic               accept;
    logic [SRC_W-1:0]   pop_src;
    logic [DATA_W-1:0]  pop_data;

    always_comb begin
        slot_free = ~out_valid_q | bus.out_ready;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Ready depends on registered count only; a same-cycle pop does
            // not open a slot in a full FIFO.
            in_ready_w[i] = (count_q[i] != CNT_W'(DEPTH));
            // Masking req while stalled keeps the arbiter's LRU state frozen.
            req_w[i]      = (count_q[i] != '0) & slot_free;
            push[i]       = bus.in_valid[i] & in_ready_w[i];
        end
    end

    always_comb begin
        gnt_onehot = (bus.gnt != '0) && ((bus.gnt & (bus.gnt - NUM_REQ'(1))) == '0);
        gnt_legal  = gnt_onehot && ((bus.gnt & ~req_w) == '0);
        accept     = slot_free & gnt_legal;
        pop        = accept ? bus.gnt : '0;
    end

    // One-hot pop makes an OR-mux sufficient for index and payload.
    always_comb begin
        pop_src  = '0;
        pop_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pop[i]) begin
                pop_src  = pop_src | SRC_W'(i);
                pop_data = pop_data | mem_q[i][rptr_q[i]];
            end
        end
    end

    // Storage array is not reset; counts gate every read of it.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            gnt_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pop_data;
                out_src_q   <= pop_src;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Any nonzero grant that is not accepted as legal is a protocol error.
            if ((bus.gnt != '0) && !gnt_legal) begin
                gnt_err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.req       = req_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.gnt_err   = gnt_err_q;
endmodule

// File: tb/tb_lru_req_queue.sv
// Directed bench for lru_req_queue. A lowest-index arbiter model supplies
// gnt when enabled; otherwise gnt comes from gnt_force for illegal-grant cases.
// Completed output transfers are logged at the falling edge.
module tb_lru_req_queue;
    localparam int unsigned NUM_REQ = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SRC_W   = 4;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic arb_en = 1'b1;
    logic [NUM_REQ-1:0] gnt_force = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] got_q[$];

    lru_req_queue_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

    lru_req_queue #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .DEPTH  (4),
        .SRC_W  (SRC_W)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.gnt = arb_en ? (bus.req & (~bus.req + NUM_REQ'(1))) : gnt_force;

    always @(negedge clk) begin
        if (rst_b && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATA_W-1:0] d);
        bus.in_data[idx*DATA_W +: DATA_W] = d;
    endtask

    task automatic check_queue(input string tag, input logic [DATA_W-1:0] exp[$]);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset and idle
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_in_ready", 64'(bus.in_ready), 64'h3FF);
            check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        end
        rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle_in_ready", 64'(bus.in_ready), 64'h3FF);
            check("idle_req", 64'(bus.req), 64'h0);
            check("idle_out_valid", 64'(bus.out_valid), 64'h0);
            check("idle_gnt_err", 64'(bus.gnt_err), 64'h0);
        end

        // Single push latency on requester 3
        got_q.delete();
        set_data(3, 32'hA5A5_0003);
        bus.in_valid[3] = 1'b1;
        check("lat_req_c0", 64'(bus.req), 64'h0);
        step();
        bus.in_valid[3] = 1'b0;
        check("lat_req_c1", 64'(bus.req), 64'h008);
        step();
        check("lat_valid_c2", 64'(bus.out_valid), 64'h1);
        check("lat_data_c2", 64'(bus.out_data), 64'hA5A5_0003);
        check("lat_src_c2", 64'(bus.out_src), 64'h3);
        check("lat_req_empty", 64'(bus.req), 64'h0);
        step();
        check("lat_valid_drop", 64'(bus.out_valid), 64'h0);

        // Full and wrap on requester 0
        got_q.delete();
        arb_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid[0] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            set_data(0, DATA_W'(j));
            step();
        end
        check("full_in_ready", 64'(bus.in_ready[0]), 64'h0);
        set_data(0, 32'h99);
        step();
        bus.in_valid[0] = 1'b0;
        check("full_refuse", 64'(bus.in_ready[0]), 64'h0);
        arb_en = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) step();
        check("drain_in_ready", 64'(bus.in_ready[0]), 64'h1);
        bus.in_valid[0] = 1'b1;
        set_data(0, 32'd5);
        step();
        set_data(0, 32'd6);
        step();
        bus.in_valid[0] = 1'b0;
        repeat (5) step();
        check_queue("wrap", '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6});

        // Backpressure with requesters 1 and 2
        got_q.delete();
        arb_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 10'h006;
        for (int j = 0; j < 4; j++) begin
            set_data(1, 32'h100 + DATA_W'(j));
            set_data(2, 32'h200 + DATA_W'(j));
            step();
        end
        bus.in_valid = '0;
        check("bp_full", 64'(bus.in_ready[2:1]), 64'h0);
        arb_en = 1'b1;
        check("bp_req_pre", 64'(bus.req), 64'h006);
        step();
        for (int c = 0; c < 3; c++) begin
            check("bp_req_stall", 64'(bus.req), 64'h0);
            check("bp_data_stable", 64'(bus.out_data), 64'h100);
            check("bp_src", 64'(bus.out_src), 64'h1);
            step();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            check("bp_stream_valid", 64'(bus.out_valid), 64'h1);
        end
        step();
        check("bp_end_valid", 64'(bus.out_valid), 64'h0);
        check_queue("bp", '{32'h100, 32'h101, 32'h102, 32'h103,
                            32'h200, 32'h201, 32'h202, 32'h203});

        // Illegal grants with requesters 1 and 2 full
        got_q.delete();
        arb_en = 1'b0;
        bus.in_valid = 10'h006;
        for (int j = 0; j < 4; j++) begin
            set_data(1, 32'h310 + DATA_W'(j));
            set_data(2, 32'h320 + DATA_W'(j));
            step();
        end
        bus.in_valid = '0;
        check("ill_req", 64'(bus.req), 64'h006);
        gnt_force = 10'h006;
        step();
        check("ill_multi_err", 64'(bus.gnt_err), 64'h1);
        check("ill_multi_valid", 64'(bus.out_valid), 64'h0);
        check("ill_multi_cnt", 64'(bus.in_ready[2:1]), 64'h0);
        gnt_force = 10'h010;
        step();
        check("ill_unreq_valid", 64'(bus.out_valid), 64'h0);
        check("ill_unreq_cnt", 64'(bus.in_ready[2:1]), 64'h0);
        check("ill_unreq_req", 64'(bus.req), 64'h006);
        gnt_force = '0;
        repeat (2) step();
        check("ill_sticky", 64'(bus.gnt_err), 64'h1);
        check("ill_no_xfer", 64'(got_q.size()), 64'h0);

        // Reset mid-operation: FIFOs 1, 2, 5 hold data and output is loaded
        bus.out_ready = 1'b0;
        bus.in_valid[5] = 1'b1;
        set_data(5, 32'h500);
        step();
        bus.in_valid = '0;
        arb_en = 1'b1;
        step();
        check("mid_valid_pre", 64'(bus.out_valid), 64'h1);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_valid_async", 64'(bus.out_valid), 64'h0);
        check("mid_in_ready", 64'(bus.in_ready), 64'h3FF);
        check("mid_gnt_err", 64'(bus.gnt_err), 64'h0);
        #1;
        rst_b = 1'b1;
        got_q.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_req", 64'(bus.req), 64'h0);
            check("post_valid", 64'(bus.out_valid), 64'h0);
            check("post_data", 64'(bus.out_data), 64'h0);
        end
        check("post_no_xfer", 64'(got_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lru_req_queue.md
Name: lru_req_queue

Overview:
- Per-requester ingress buffering that sits directly upstream of the LRU (matrix) arbiter.
- Each requester pushes payloads into its own small FIFO.
- The block presents a request vector to the arbiter, consumes the arbiter's one-hot grant, pops the granted FIFO, and registers the winning payload into a single valid/ready output stage for the downstream consumer.

Parameters:
- NUM_REQ, 10, number of requesters; matches arbiter width.
- DATA_W, 32, payload width per requester.
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.
- SRC_W, $clog2(NUM_REQ), width of the source index output.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- in_valid  input  NUM_REQ  per-requester push valid.
- in_ready  output  NUM_REQ  per-requester push ready.
- in_data  input  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req  output  NUM_REQ  request vector to arbiter.
- gnt  input  NUM_REQ  grant vector from arbiter; combinational, same cycle as req.
- out_valid  output  1  winning payload valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  winning payload.
- out_src  output  SRC_W  index of the winning requester.
- gnt_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, synchronous to clk on deassert):
  - all FIFO counts and read/write pointers go to 0.
  - out_valid=0, out_data=0, out_src=0, gnt_err=0.
  - in_ready is all-ones after reset (every FIFO is empty).
  - A reset mid-operation discards all queued and output-stage data with no drain.
- Per-FIFO storage:
  - count width is $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
  - in_ready[i] = (count[i] != DEPTH). It is registered-state derived, with no combinational path from gnt or out_ready.
  - push[i] = in_valid[i] & in_ready[i]. Data is written at wptr[i] and wptr increments.
  - No bypass: a push into an empty FIFO raises req[i] on the next cycle.
  - Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
  - A full FIFO refuses a push even when a pop occurs in the same cycle.
- Output-stage slot:
  - slot_free = ~out_valid | out_ready.
  - req[i] = (count[i] != 0) & slot_free. All requests are masked while the output is stalled, so the arbiter's LRU state is not updated by grants that cannot be consumed.
- Grant acceptance:
  - accept = slot_free & (gnt != 0) & gnt_legal.
  - gnt_legal means gnt is one-hot and (gnt & ~req) == 0.
  - On accept with gnt[k]=1:
    - pop FIFO k (rptr[k] increments, count decrements unless a push occurs in the same cycle).
    - on the next edge: out_data <= mem[k][rptr[k]], out_src <= k, out_valid <= 1.
  - If slot_free & ~accept & out_ready: out_valid <= 0.
  - If out_valid & ~out_ready: out_data, out_src and out_valid hold.
- Illegal grants:
  - Covers multi-hot gnt, or gnt to a requester with req=0.
  - No pop occurs and the output is unchanged for that cycle.
  - gnt_err is set and stays set until reset.
- Throughput and latency:
  - With out_ready held high, one payload per cycle. Back-to-back accepts are permitted.
  - Latency from a push at edge t: req visible after edge t, gnt in that cycle, out_valid after edge t+1. Two cycles push-to-output, minimum.
- Ordering: per-requester FIFO order is preserved. Cross-requester order is determined solely by the arbiter.
- No data path may depend on gnt bits outside the range [NUM_REQ-1:0].

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_b=0 for 3 cycles, then release with no input.
  - Required: in_ready=10'h3FF, req=0, out_valid=0, gnt_err=0 throughout.
- Single push latency:
  - Stimulus: push 32'hA5A5_0003 on requester 3 at cycle 0; arbiter model grants gnt=10'h008 when req[3]=1.
  - Required: req[3] rises at cycle 1; out_valid=1, out_data=32'hA5A5_0003, out_src=3 at cycle 2; FIFO 3 count returns to 0.
- Full and wrap:
  - Stimulus: push 4 words (1,2,3,4) into requester 0 with out_ready=0.
  - Required: in_ready[0]=0 after the 4th push and a 5th push is refused.
  - Then set out_ready=1, drain, and push 5,6.
  - Required: output order 1,2,3,4,5,6, exercising pointer wrap.
- Backpressure:
  - Stimulus: fill requesters 1 and 2, hold out_ready=0 while out_valid=1.
  - Required: req=0 while stalled, out_data stable.
  - Stimulus: release out_ready.
  - Required: transfers resume one per cycle.
- Illegal grant:
  - Stimulus: with req=10'h006, drive gnt=10'h006 (multi-hot), then gnt=10'h010 (unrequested).
  - Required: no pop, counts unchanged, gnt_err=1 and sticky.
- Reset mid-operation:
  - Stimulus: with 3 FIFOs holding data and out_valid=1, pulse rst_b low asynchronously between clock edges.
  - Required: out_valid drops immediately, all counts are 0 after release, and no stale data ever appears on out_data.
